// File: rtl/sram_lsu_pkg.sv
// Shared encodings for the SRAM load/store unit: access sizes, FSM states and alignment rule.
package lsu_pkg;
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_X = 2'b11;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        CAP  = 3'd2,
        WR   = 3'd3,
        RSP  = 3'd4
    } lsu_state_e;

    // Illegal size is reported separately; this only covers natural alignment.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_H:    return off[0];
            SZ_W:    return (off != 2'b00);
            default: return 1'b0;
        endcase
    endfunction
endpackage

// File: rtl/sram_lsu_if.sv
// Core request/response channel plus the SRAM pins, bundled for the LSU.
interface sram_lsu_if #(parameter int AW = 10);
    logic          REQ_VALID;
    logic          REQ_READY;
    logic          REQ_WE;
    logic [1:0]    REQ_SIZE;
    logic          REQ_SIGNED;
    logic [31:0]   REQ_ADDR;
    logic [31:0]   REQ_WDATA;
    logic          RSP_VALID;
    logic          RSP_READY;
    logic [31:0]   RSP_RDATA;
    logic          RSP_ERR;
    logic          MEM_CSN;
    logic          MEM_WEN;
    logic [AW-1:0] MEM_A;
    logic [31:0]   MEM_DI;
    logic [31:0]   MEM_DOUT;

    // master = core plus SRAM side, slave = the LSU itself
    modport master (
        output REQ_VALID, REQ_WE, REQ_SIZE, REQ_SIGNED, REQ_ADDR, REQ_WDATA, RSP_READY, MEM_DOUT,
        input  REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR, MEM_CSN, MEM_WEN, MEM_A, MEM_DI
    );
    modport slave (
        input  REQ_VALID, REQ_WE, REQ_SIZE, REQ_SIGNED, REQ_ADDR, REQ_WDATA, RSP_READY, MEM_DOUT,
        output REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR, MEM_CSN, MEM_WEN, MEM_A, MEM_DI
    );
endinterface

// File: rtl/sram_lsu_align.sv
// Lane steering: extracts/extends load data and merges sub-word store data into an old word.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] rword_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  off_i,
    input  logic [1:0]  size_i,
    input  logic        sgn_i,
    output logic [31:0] ld_data_o,
    output logic [31:0] st_word_o
);
    logic [31:0] b_sh;
    logic [7:0]  b_v;
    logic [15:0] h_v;
    logic [31:0] b_mask;
    logic [31:0] h_mask;

    assign b_sh   = rword_i >> {off_i, 3'b000};
    assign b_v    = b_sh[7:0];
    assign h_v    = off_i[1] ? rword_i[31:16] : rword_i[15:0];
    assign b_mask = 32'h0000_00FF << {off_i, 3'b000};
    assign h_mask = 32'h0000_FFFF << {off_i[1], 4'b0000};

    always_comb begin
        ld_data_o = 32'd0;
        case (size_i)
            SZ_B:    ld_data_o = {{24{sgn_i & b_v[7]}}, b_v};
            SZ_H:    ld_data_o = {{16{sgn_i & h_v[15]}}, h_v};
            SZ_W:    ld_data_o = rword_i;
            default: ld_data_o = 32'd0;
        endcase
    end

    always_comb begin
        st_word_o = wdata_i;
        case (size_i)
            SZ_B:    st_word_o = (rword_i & ~b_mask) | ((wdata_i & 32'h0000_00FF) << {off_i, 3'b000});
            SZ_H:    st_word_o = (rword_i & ~h_mask) | ((wdata_i & 32'h0000_FFFF) << {off_i[1], 4'b0000});
            default: st_word_o = wdata_i;
        endcase
    end
endmodule

// File: rtl/sram_lsu.sv
// Load/store initiator for a single-port SRAM; sub-word stores are read-modify-write.
// Define LSU_RANGE_CHK_EN to reject addresses beyond the SRAM instead of aliasing them.
module sram_lsu
    import lsu_pkg::*;
#(
    parameter int AW = 10
) (
    input  logic      CLK,
    input  logic      RST,
    sram_lsu_if.slave bus
);
    lsu_state_e    state_q, state_d;
    logic          we_q, sgn_q;
    logic [1:0]    size_q, off_q;
    logic [31:0]   wdata_q;
    logic          rsp_valid_q, rsp_err_q;
    logic [31:0]   rdata_q;
    logic          csn_q, wen_q;
    logic [AW-1:0] a_q;
    logic [31:0]   di_q;
    logic [31:0]   ld_data, st_word;
    logic          accept, range_err, req_err, word_st;

    assign bus.REQ_READY = (state_q == IDLE) & ~RST;
    assign accept        = bus.REQ_VALID & bus.REQ_READY;

`ifdef LSU_RANGE_CHK_EN
    assign range_err = (bus.REQ_ADDR >> (AW + 2)) != 32'd0;
`else
    assign range_err = 1'b0;
`endif

    assign req_err = is_misaligned(bus.REQ_SIZE, bus.REQ_ADDR[1:0])
                   | (bus.REQ_SIZE == SZ_X) | range_err;
    assign word_st = bus.REQ_WE & (bus.REQ_SIZE == SZ_W);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = req_err ? RSP : (word_st ? WR : RD);
            RD:   state_d = CAP;
            CAP:  state_d = we_q ? WR : RSP;
            WR:   state_d = RSP;
            RSP:  if (bus.RSP_READY) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    lsu_align u_align (
        .rword_i   (bus.MEM_DOUT),
        .wdata_i   (wdata_q),
        .off_i     (off_q),
        .size_i    (size_q),
        .sgn_i     (sgn_q),
        .ld_data_o (ld_data),
        .st_word_o (st_word)
    );

    // SRAM strobes are decoded from the next state so they are registered and last one cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            sgn_q       <= 1'b0;
            size_q      <= SZ_B;
            off_q       <= 2'b00;
            wdata_q     <= 32'd0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rdata_q     <= 32'd0;
            csn_q       <= 1'b1;
            wen_q       <= 1'b1;
            a_q         <= '0;
            di_q        <= 32'd0;
        end else begin
            state_q     <= state_d;
            csn_q       <= ~((state_d == RD) | (state_d == WR));
            wen_q       <= ~(state_d == WR);
            rsp_valid_q <= (state_d == RSP);
            if (accept) begin
                we_q      <= bus.REQ_WE;
                sgn_q     <= bus.REQ_SIGNED;
                size_q    <= bus.REQ_SIZE;
                off_q     <= bus.REQ_ADDR[1:0];
                wdata_q   <= bus.REQ_WDATA;
                rsp_err_q <= req_err;
                rdata_q   <= 32'd0;
                if (!req_err) a_q <= bus.REQ_ADDR[AW+1:2];
                if (!req_err && word_st) di_q <= bus.REQ_WDATA;
            end
            if (state_q == CAP) begin
                if (we_q) di_q    <= st_word;
                else      rdata_q <= ld_data;
            end
        end
    end

    assign bus.RSP_VALID = rsp_valid_q;
    assign bus.RSP_ERR   = rsp_err_q;
    assign bus.RSP_RDATA = rdata_q;
    assign bus.MEM_CSN   = csn_q;
    assign bus.MEM_WEN   = wen_q;
    assign bus.MEM_A     = a_q;
    assign bus.MEM_DI    = di_q;
endmodule

// File: tb/tb_sram_lsu.sv
// Random and directed bench for sram_lsu against a byte-addressed memory model and an SRAM model.
module tb_sram_lsu;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mem_clr = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   rd_cnt = 0;
    int   wr_cnt = 0;
    logic prev_low = 1'b0;
    logic [7:0]  shadow [4096];
    logic [31:0] mem [1024];

    sram_lsu_if #(.AW(10)) bus ();
    sram_lsu #(.AW(10)) dut (.CLK(clk), .RST(rst), .bus(bus));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'd0;
        end else if (!bus.MEM_CSN) begin
            if (!bus.MEM_WEN) mem[bus.MEM_A] <= bus.MEM_DI;
            else              bus.MEM_DOUT <= #2 mem[bus.MEM_A];
        end
    end

    always @(posedge clk) begin
        if (!bus.MEM_CSN) begin
            chk("csn_gap", {31'd0, prev_low}, 32'd0);
            if (bus.MEM_WEN) rd_cnt++;
            else             wr_cnt++;
        end
        prev_low = !bus.MEM_CSN;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic model_err(input logic [1:0] size, input logic [31:0] addr);
        logic e;
        e = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0);
`ifdef LSU_RANGE_CHK_EN
        e = e || (addr[31:12] != 20'd0);
`endif
        return e;
    endfunction

    // Little-endian byte memory; n bytes starting at the (aligned) byte address.
    function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [1:0] size, input logic sgn);
        int     n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        longint v = 0;
        for (int i = 0; i < n; i++) v += longint'(shadow[(addr[11:0] + i) % 4096]) << (8 * i);
        if (sgn && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    task automatic model_store(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] wdata);
        int n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        for (int i = 0; i < n; i++) shadow[(addr[11:0] + i) % 4096] = 8'((wdata >> (8 * i)) & 32'hFF);
    endtask

    task automatic do_req(input logic we, input logic [1:0] size, input logic sgn, input logic [31:0] addr,
                          input logic [31:0] wdata, input int bp, output logic [31:0] got);
        logic        e;
        logic [31:0] exp_d;
        int          exp_lat, lat, n, rd0, wr0;
        e       = model_err(size, addr);
        exp_d   = (e || we) ? 32'd0 : model_load(addr, size, sgn);
        exp_lat = e ? 1 : !we ? 3 : (size == 2'd2) ? 2 : 4;
        rd0     = rd_cnt;
        wr0     = wr_cnt;
        @(negedge clk);
        bus.REQ_VALID  = 1'b1;
        bus.REQ_WE     = we;
        bus.REQ_SIZE   = size;
        bus.REQ_SIGNED = sgn;
        bus.REQ_ADDR   = addr;
        bus.REQ_WDATA  = wdata;
        bus.RSP_READY  = (bp == 0);
        n = 0;
        while (!bus.REQ_READY && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready", {31'd0, bus.REQ_READY}, 32'd1);
        @(posedge clk);
        #1;
        bus.REQ_VALID  = 1'b0;
        bus.REQ_WE     = 1'($urandom);
        bus.REQ_SIZE   = 2'($urandom);
        bus.REQ_SIGNED = 1'($urandom);
        bus.REQ_ADDR   = $urandom;
        bus.REQ_WDATA  = $urandom;
        if (!e && we) model_store(addr, size, wdata);
        lat = 1;
        while (!bus.RSP_VALID && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", lat, exp_lat);
        chk("rdata", bus.RSP_RDATA, exp_d);
        chk("err", {31'd0, bus.RSP_ERR}, {31'd0, e});
        got = bus.RSP_RDATA;
        for (int i = 0; i < bp; i++) begin
            @(posedge clk);
            #1;
            chk("hold_valid", {31'd0, bus.RSP_VALID}, 32'd1);
            chk("hold_rdata", bus.RSP_RDATA, exp_d);
            chk("hold_reqrdy", {31'd0, bus.REQ_READY}, 32'd0);
        end
        bus.RSP_READY = 1'b1;
        @(posedge clk);
        #1;
        chk("valid_drop", {31'd0, bus.RSP_VALID}, 32'd0);
        chk("reqrdy_back", {31'd0, bus.REQ_READY}, 32'd1);
        chk("rd_strobes", rd_cnt - rd0, (!e && (!we || size != 2'd2)) ? 1 : 0);
        chk("wr_strobes", wr_cnt - wr0, (!e && we) ? 1 : 0);
    endtask

    initial begin
        logic [31:0] got, addr;
        logic [1:0]  sz;
        int          wr0, nbad;
        for (int i = 0; i < 4096; i++) shadow[i] = 8'd0;
        bus.REQ_VALID  = 1'b0;
        bus.REQ_WE     = 1'b0;
        bus.REQ_SIZE   = 2'd0;
        bus.REQ_SIGNED = 1'b0;
        bus.REQ_ADDR   = 32'd0;
        bus.REQ_WDATA  = 32'd0;
        bus.RSP_READY  = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_reqrdy", {31'd0, bus.REQ_READY}, 32'd0);
        chk("rst_valid", {31'd0, bus.RSP_VALID}, 32'd0);
        chk("rst_err", {31'd0, bus.RSP_ERR}, 32'd0);
        chk("rst_rdata", bus.RSP_RDATA, 32'd0);
        chk("rst_csn", {31'd0, bus.MEM_CSN}, 32'd1);
        chk("rst_wen", {31'd0, bus.MEM_WEN}, 32'd1);
        chk("rst_a", {22'd0, bus.MEM_A}, 32'd0);
        chk("rst_di", bus.MEM_DI, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        mem_clr = 1'b0;
        #1;
        chk("post_rst_rdy", {31'd0, bus.REQ_READY}, 32'd1);

        do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 0, got);
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 0, got);
        chk("t1_word", got, 32'hDEADBEEF);

        do_req(1'b1, 2'd2, 1'b0, 32'h20, 32'h11223344, 0, got);
        do_req(1'b1, 2'd0, 1'b0, 32'h21, 32'h000000AA, 0, got);
        do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'd0, 0, got);
        chk("t2_merge", got, 32'h1122AA44);

        do_req(1'b1, 2'd2, 1'b0, 32'h30, 32'h80F0807F, 0, got);
        do_req(1'b0, 2'd0, 1'b1, 32'h31, 32'd0, 0, got);
        chk("t3_bs", got, 32'hFFFFFF80);
        do_req(1'b0, 2'd0, 1'b0, 32'h31, 32'd0, 0, got);
        chk("t3_bu", got, 32'h00000080);
        do_req(1'b0, 2'd1, 1'b1, 32'h32, 32'd0, 0, got);
        chk("t3_hs", got, 32'hFFFF80F0);

        do_req(1'b0, 2'd2, 1'b0, 32'h6, 32'd0, 0, got);
        do_req(1'b0, 2'd1, 1'b0, 32'h3, 32'd0, 0, got);
        do_req(1'b0, 2'd3, 1'b0, 32'h40, 32'd0, 0, got);

        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 5, got);
        do_req(1'b0, 2'd1, 1'b0, 32'h12, 32'd0, 0, got);
        chk("t5_next", got, 32'h0000DEAD);

        do_req(1'b1, 2'd2, 1'b0, 32'h40, 32'h55667788, 0, got);
        wr0 = wr_cnt;
        @(negedge clk);
        bus.REQ_VALID  = 1'b1;
        bus.REQ_WE     = 1'b1;
        bus.REQ_SIZE   = 2'd0;
        bus.REQ_ADDR   = 32'h42;
        bus.REQ_WDATA  = 32'h99;
        chk("t6_rdy", {31'd0, bus.REQ_READY}, 32'd1);
        @(posedge clk);
        #1;
        bus.REQ_VALID = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("t6_rdy_rst", {31'd0, bus.REQ_READY}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("t6_valid", {31'd0, bus.RSP_VALID}, 32'd0);
        chk("t6_rdy_after", {31'd0, bus.REQ_READY}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("t6_no_wr", wr_cnt - wr0, 32'd0);
        chk("t6_valid2", {31'd0, bus.RSP_VALID}, 32'd0);
        do_req(1'b0, 2'd2, 1'b0, 32'h40, 32'd0, 0, got);
        chk("t6_mem", got, 32'h55667788);

`ifdef LSU_RANGE_CHK_EN
        do_req(1'b0, 2'd2, 1'b0, 32'h00001000, 32'd0, 0, got);
        chk("range_err", {31'd0, bus.RSP_ERR}, 32'd1);
`endif

        for (int t = 0; t < 160; t++) begin
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            addr = 32'($urandom_range(0, 15)) << 2;
            if (sz == 2'd0) addr[1:0] = 2'($urandom_range(0, 3));
            if (sz == 2'd1) addr[1]   = 1'($urandom);
            if ($urandom_range(0, 7) == 0) addr[1:0] = 2'($urandom);
            if ($urandom_range(0, 7) == 0) addr[31:12] = 20'($urandom);
            do_req(1'($urandom), sz, 1'($urandom), addr, $urandom,
                   ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0, got);
        end

        nbad = 0;
        for (int w = 0; w < 1024; w++)
            if (mem[w] !== {shadow[4*w+3], shadow[4*w+2], shadow[4*w+1], shadow[4*w]}) nbad++;
        chk("mem_final", nbad, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
